// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock key front-end.
//   - chan_state_t : per-key channel state (IDLE, HELD_DELAY, HELD_REPEAT)
//   - CLK_HZ / SAMPLE_20MS : default clock rate and 20 ms sample divisor
//   - KEY_MODEL / KEY_SUB / KEY_ADD : bit positions of the board keys
//   - cnt_width() : counter width helper, never returns less than 1 bit
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int SAMPLE_20MS = CLK_HZ / 50;

  localparam int KEY_MODEL = 0;
  localparam int KEY_SUB   = 1;
  localparam int KEY_ADD   = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } chan_state_t;

  // Bits needed for a counter whose values run 0..n-1; a 1-bit floor keeps
  // degenerate parameter values from producing zero-width vectors.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One key's worth of conditioning: 2-flop synchroniser, sample-rate
// debouncer and the hold/auto-repeat channel FSM.
//
// Build option: KEY_REPEAT_EN
//   defined   -> repeat counter, HELD_REPEAT state, repeat_en/repeat_pulse
//                ports and REPEAT_DELAY/REPEAT_RATE parameters are built
//   undefined -> FSM only tracks IDLE/HELD_DELAY; no repeat logic
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   key_n         raw asynchronous key, active-low
//   sample_tick   one-cycle strobe from the shared divider
//   repeat_en     this key may auto-repeat (KEY_REPEAT_EN builds only)
//   level         debounced level, active-high
//   press_pulse   one-cycle pulse on debounced press
//   release_pulse one-cycle pulse on debounced release
//   repeat_pulse  press pulse plus auto-repeats (KEY_REPEAT_EN builds only)
// ---------------------------------------------------------------------------
module key_channel
  import clock_pkg::*;
#(
  parameter int STABLE_SAMPLES = 2
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 5
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic sample_tick,
`ifdef KEY_REPEAT_EN
  input  logic repeat_en,
  output logic repeat_pulse,
`endif
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int STABLE_W = cnt_width(STABLE_SAMPLES);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_SAMPLES - 1);

  logic                sync_meta;
  logic                sync_key;
  logic                key_s;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_cnt_d;
  logic                level_d;
  logic                press_d;
  logic                release_d;
  chan_state_t         state;
  chan_state_t         state_d;

  // Two-flop synchroniser. Reset loads the released (high) value so a key
  // held through reset is seen as a brand-new press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_key  <= 1'b1;
    end else begin
      sync_meta <= key_n;
      sync_key  <= sync_meta;
    end
  end

  assign key_s = ~sync_key;

  // Debounce decision, only evaluated on the sample strobe. A disagreeing
  // sample counts up; the STABLE_SAMPLES-th disagreeing sample in a row
  // flips the level. Any agreeing sample starts the count over.
  always_comb begin
    stable_cnt_d = stable_cnt;
    level_d      = level;
    press_d      = 1'b0;
    release_d    = 1'b0;
    if (sample_tick) begin
      if (key_s != level) begin
        if (stable_cnt == STABLE_LAST) begin
          level_d      = ~level;
          stable_cnt_d = '0;
          press_d      = ~level;
          release_d    = level;
        end else begin
          stable_cnt_d = stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  // Debounced level and edge pulses are registered so the pulses appear in
  // the cycle after the strobe and last exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt    <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      stable_cnt    <= stable_cnt_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  // The counter must hold the loaded value itself, hence the +1.
  localparam int REP_W   = cnt_width(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LOAD = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] RATE_LOAD  = REP_W'(REPEAT_RATE);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_d;
  logic             repeat_d;

  // Next state and repeat scheduling. The counter is a tick countdown: a
  // repeat fires on the tick that takes it to zero. Release wins over a
  // repeat due on the same tick. Keys without repeat_en park in HELD_DELAY
  // with the counter held at zero until released.
  always_comb begin
    state_d   = state;
    rep_cnt_d = rep_cnt;
    repeat_d  = 1'b0;
    case (state)
      IDLE: begin
        if (press_d) begin
          state_d   = HELD_DELAY;
          rep_cnt_d = DELAY_LOAD;
          repeat_d  = 1'b1;
        end
      end
      HELD_DELAY: begin
        if (release_d) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (sample_tick) begin
          if (repeat_en && (rep_cnt <= REP_ONE)) begin
            state_d   = HELD_REPEAT;
            rep_cnt_d = RATE_LOAD;
            repeat_d  = 1'b1;
          end else if (rep_cnt != '0) begin
            rep_cnt_d = rep_cnt - 1'b1;
          end
        end
      end
      HELD_REPEAT: begin
        if (release_d) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (sample_tick) begin
          if (rep_cnt <= REP_ONE) begin
            rep_cnt_d = RATE_LOAD;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = '0;
      end
    endcase
  end

  // Repeat counter and registered repeat pulse, aligned with press_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= rep_cnt_d;
      repeat_pulse <= repeat_d;
    end
  end
`else
  // Without auto-repeat the channel only tracks whether the key is held.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (press_d) begin
          state_d = HELD_DELAY;
        end
      end
      HELD_DELAY: begin
        if (release_d) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`endif

endmodule

// File: rtl/key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// key_debounce_repeat
// Key front-end for the digital clock. Synchronises and debounces the raw
// active-low board keys and hands the display block clean one-cycle pulses
// (press, release, repeat) plus the debounced levels.
//
// Build option: KEY_REPEAT_EN
//   defined   -> held REPEAT_MASK keys auto-repeat after REPEAT_DELAY ticks,
//                then every REPEAT_RATE ticks
//   undefined -> no repeat hardware; key_repeat is identical to key_press
//
// Ports:
//   clk          system clock (50 MHz)
//   rst          synchronous reset, active-high
//   key_in       raw keys, active-low, {add, sub, model} = [2:0]
//   key_level    debounced level, active-high
//   key_press    one-cycle pulse on debounced press
//   key_release  one-cycle pulse on debounced release
//   key_repeat   press pulse plus auto-repeats while held
//   sample_tick  one-cycle strobe at each sample instant
// ---------------------------------------------------------------------------
module key_debounce_repeat
  import clock_pkg::*;
#(
  parameter int                SAMPLE_CYCLES  = SAMPLE_20MS,
  parameter int                STABLE_SAMPLES = 2,
  parameter int                N_KEYS         = 3,
  parameter logic [N_KEYS-1:0] REPEAT_MASK    = N_KEYS'((1 << KEY_ADD) | (1 << KEY_SUB)),
  parameter int                REPEAT_DELAY   = 25,
  parameter int                REPEAT_RATE    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              sample_tick
);

  localparam int DIV_W = cnt_width(SAMPLE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_CYCLES - 1);

  // Reject parameter sets that would break counter sizing or wrap.
  if (SAMPLE_CYCLES < 2 || STABLE_SAMPLES < 1 || N_KEYS < 1 ||
      REPEAT_DELAY < 0 || REPEAT_RATE < 1 || REPEAT_MASK > {N_KEYS{1'b1}}) begin : g_bad_params
    $error("key_debounce_repeat: illegal parameter combination");
  end

  logic [DIV_W-1:0] div_cnt;

  // Shared sample divider: counts 0..SAMPLE_CYCLES-1 and wraps; the last
  // count is the sample instant for every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sample_tick = (div_cnt == DIV_LAST);

  // One independent channel per key; only the repeat enable differs.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
`ifdef KEY_REPEAT_EN
    key_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_n         (key_in[i]),
      .sample_tick   (sample_tick),
      .repeat_en     (REPEAT_MASK[i]),
      .repeat_pulse  (key_repeat[i]),
      .level         (key_level[i]),
      .press_pulse   (key_press[i]),
      .release_pulse (key_release[i])
    );
`else
    key_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_n         (key_in[i]),
      .sample_tick   (sample_tick),
      .level         (key_level[i]),
      .press_pulse   (key_press[i]),
      .release_pulse (key_release[i])
    );
`endif
  end

`ifndef KEY_REPEAT_EN
  assign key_repeat = key_press;
`endif

endmodule
